// File: rtl/sprite_pkg.sv
// Shared widths, types and constants for the sprite pixel fetch path.
// Imported by the frame counter and the fetch pipeline.
package sprite_pkg;

    localparam int ADDR_W  = 19;
    localparam int RGB_W   = 24;
    localparam int COORD_W = 10;

    typedef logic [RGB_W-1:0]   rgb_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam rgb_t KEY_MAGENTA = 24'hFF00FF;

endpackage

// File: rtl/sprite_pixel_fetch_anim_frame_counter.sv
// Animation frame index: divides frame_start pulses by FRAME_DIV and
// steps a frame index modulo NUM_FRAMES; only moves on frame_start.
module anim_frame_counter
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_DIV  = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    output logic [1:0] anim_frame
);

    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
    localparam logic [1:0]    FRM_LAST = 2'(NUM_FRAMES - 1);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    frm_q, frm_d;

    // Next divider count and frame index for this frame_start
    always_comb begin
        div_d = div_q;
        frm_d = frm_q;
        if (frame_start) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                frm_d = (frm_q == FRM_LAST) ? 2'd0 : frm_q + 2'd1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    // Divider and frame index registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q <= '0;
            frm_q <= '0;
        end else begin
            div_q <= div_d;
            frm_q <= frm_d;
        end
    end

    assign anim_frame = frm_q;

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: hit test and ROM address, ROM latency absorption,
// chroma key, and a 3-cycle streaming pixel/valid output.
module sprite_pixel_fetch
    import sprite_pkg::*;
#(
    parameter int   SPR_W      = 32,
    parameter int   SPR_H      = 32,
    parameter int   NUM_FRAMES = 4,
    parameter int   FRAME_DIV  = 8,
    parameter rgb_t KEY_COLOR  = KEY_MAGENTA
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              pixel_en,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  coord_t            obj_x,
    input  coord_t            obj_y,
    input  logic              obj_en,
    input  logic              flip_x,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        rom_sel,
    input  rgb_t              rom_data,
    output logic              pix_valid,
    output rgb_t              pix_rgb,
    output logic [1:0]        anim_frame
);

    localparam logic signed [COORD_W:0] XMAX = (COORD_W+1)'(SPR_W - 1);
    localparam logic signed [COORD_W:0] YMAX = (COORD_W+1)'(SPR_H - 1);
    localparam logic signed [COORD_W:0] ZERO = '0;

    logic signed [COORD_W:0] lx, ly;
    logic [COORD_W:0]        col;
    logic [ADDR_W-1:0]       addr;
    logic                    hit;

    logic [ADDR_W-1:0] rom_addr_q;
    logic [1:0]        rom_sel_q;
    logic              hit1_q, hit2_q;
    logic              pix_valid_q;
    rgb_t              pix_rgb_q;
    logic              opaque;

    anim_frame_counter #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_DIV  (FRAME_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .anim_frame  (anim_frame)
    );

    // Offsets are signed so a scan left of / above the sprite never wraps
    assign lx = $signed({1'b0, DrawX}) - $signed({1'b0, obj_x});
    assign ly = $signed({1'b0, DrawY}) - $signed({1'b0, obj_y});

    assign hit = pixel_en & obj_en
               & (lx >= ZERO) & (lx <= XMAX)
               & (ly >= ZERO) & (ly <= YMAX);

    assign col  = flip_x ? (COORD_W+1)'(XMAX - lx) : (COORD_W+1)'(lx);
    assign addr = ADDR_W'(ly[COORD_W-1:0]) * ADDR_W'(SPR_W)
                + ADDR_W'(col[COORD_W-1:0]);

    assign opaque = hit2_q & (rom_data != KEY_COLOR);

    // Three-stage pipeline: address issue, ROM wait, chroma key
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            rom_sel_q   <= '0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_rgb_q   <= '0;
        end else begin
            rom_addr_q  <= hit ? addr : '0;
            rom_sel_q   <= anim_frame;
            hit1_q      <= hit;
            hit2_q      <= hit1_q;
            pix_valid_q <= opaque;
            pix_rgb_q   <= opaque ? rom_data : '0;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_sel   = rom_sel_q;
    assign pix_valid = pix_valid_q;
    assign pix_rgb   = pix_rgb_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch: driver queues expected
// address and pixel results, a negedge monitor pops and compares.
module tb_sprite_pixel_fetch;
    import sprite_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              frame_start, pixel_en, obj_en, flip_x;
    coord_t            DrawX, DrawY, obj_x, obj_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        rom_sel;
    rgb_t              rom_data;
    logic              pix_valid;
    rgb_t              pix_rgb;
    logic [1:0]        anim_frame;

    sprite_pixel_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .pixel_en    (pixel_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_en      (obj_en),
        .flip_x      (flip_x),
        .rom_addr    (rom_addr),
        .rom_sel     (rom_sel),
        .rom_data    (rom_data),
        .pix_valid   (pix_valid),
        .pix_rgb     (pix_rgb),
        .anim_frame  (anim_frame)
    );

    always #5 Clk = ~Clk;

    rgb_t mem [4][1024];

    always @(posedge Clk) rom_data <= mem[rom_sel][rom_addr[9:0]];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    logic [20:0] aq [$];
    logic [24:0] pq [$];
    logic stim_valid = 1'b0;
    logic iss1, iss2, iss3;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            iss1 <= 1'b0;
            iss2 <= 1'b0;
            iss3 <= 1'b0;
        end else begin
            iss1 <= stim_valid;
            iss2 <= iss1;
            iss3 <= iss2;
        end
    end

    always @(negedge Clk) begin
        logic [20:0] ea;
        logic [24:0] ep;
        if (iss1) begin
            if (aq.size() == 0) begin
                chk("addr_q_empty", 48'd1, 48'd0);
            end else begin
                ea = aq.pop_front();
                chk("rom_addr", 48'(rom_addr), 48'(ea[18:0]));
                chk("rom_sel", 48'(rom_sel), 48'(ea[20:19]));
            end
        end
        if (iss3) begin
            if (pq.size() == 0) begin
                chk("pix_q_empty", 48'd1, 48'd0);
            end else begin
                ep = pq.pop_front();
                chk("pix", 48'({pix_valid, pix_rgb}), 48'(ep));
            end
        end else if (Reset_n === 1'b1) begin
            chk("pix_idle", 48'({pix_valid, pix_rgb}), 48'd0);
        end
    end

    int m_div = 0;
    int m_frm = 0;

    task automatic step_model();
        if (m_div == 7) begin
            m_div = 0;
            m_frm = (m_frm + 1) % 4;
        end else begin
            m_div++;
        end
    endtask

    task automatic px(input int dx, input int dy, input bit fs,
                      input bit eh, input int ea);
        rgb_t d;
        logic [18:0] a;
        a = eh ? 19'(ea) : 19'd0;
        d = mem[m_frm][a[9:0]];
        DrawX = coord_t'(dx);
        DrawY = coord_t'(dy);
        pixel_en = 1'b1;
        frame_start = fs;
        stim_valid = 1'b1;
        aq.push_back({2'(m_frm), a});
        if (eh && d != KEY_MAGENTA) pq.push_back({1'b1, d});
        else pq.push_back(25'd0);
        if (fs) step_model();
        @(posedge Clk) #1;
    endtask

    task automatic idle(input int n);
        pixel_en = 1'b0;
        frame_start = 1'b0;
        stim_valid = 1'b0;
        repeat (n) @(posedge Clk) #1;
    endtask

    task automatic pulses(input int n);
        pixel_en = 1'b0;
        stim_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step_model();
            @(posedge Clk) #1;
            frame_start = 1'b0;
            @(posedge Clk) #1;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_addr"}, 48'(rom_addr), 48'd0);
        chk({nm, "_sel"}, 48'(rom_sel), 48'd0);
        chk({nm, "_pix"}, 48'({pix_valid, pix_rgb}), 48'd0);
        chk({nm, "_anim"}, 48'(anim_frame), 48'd0);
    endtask

    initial begin
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 1024; a++)
                mem[s][a] = {3'b010, 2'(s), 9'd0, 10'(a)};
        mem[0][69] = 24'h123456;
        mem[0][99] = KEY_MAGENTA;

        Reset_n = 1'b0;
        frame_start = 1'b0;
        pixel_en = 1'b0;
        DrawX = '0;
        DrawY = '0;
        obj_x = 10'd100;
        obj_y = 10'd50;
        obj_en = 1'b1;
        flip_x = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk_zero("reset");
        Reset_n = 1'b1;
        idle(2);

        px(105, 52, 0, 1, 69);
        flip_x = 1'b1;
        px(105, 52, 0, 1, 90);
        flip_x = 1'b0;
        px(99, 52, 0, 0, 0);
        px(132, 52, 0, 0, 0);
        px(105, 49, 0, 0, 0);
        px(103, 53, 0, 1, 99);
        px(131, 81, 0, 1, 1023);
        obj_en = 1'b0;
        px(105, 52, 0, 0, 0);
        obj_en = 1'b1;
        obj_x = 10'd1000;
        px(5, 52, 0, 0, 0);
        obj_x = 10'd100;
        idle(4);

        for (int i = 0; i < 32; i++) px(100 + i, 52, 0, 1, 64 + i);
        px(132, 52, 0, 0, 0);
        idle(4);

        pulses(8);
        chk("anim_after_8", 48'(anim_frame), 48'd1);
        pulses(7);
        chk("anim_after_15", 48'(anim_frame), 48'd1);
        px(105, 52, 1, 1, 69);
        px(106, 52, 0, 1, 70);
        idle(4);
        chk("anim_after_16", 48'(anim_frame), 48'd2);
        pulses(16);
        chk("anim_after_32", 48'(anim_frame), 48'd0);
        px(105, 52, 0, 1, 69);
        idle(4);

        px(110, 60, 0, 1, 330);
        px(111, 60, 0, 1, 331);
        Reset_n = 1'b0;
        pixel_en = 1'b0;
        stim_valid = 1'b0;
        aq.delete();
        pq.delete();
        m_div = 0;
        m_frm = 0;
        #1;
        chk_zero("midrst");
        @(posedge Clk) #1;
        @(posedge Clk) #1;
        Reset_n = 1'b1;
        px(112, 60, 0, 1, 332);
        idle(6);

        chk("aq_drained", 48'(aq.size()), 48'd0);
        chk("pq_drained", 48'(pq.size()), 48'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
